// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO controller: op encodings, FSM states and
// the default length of the divider arm window.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_MTHI = 2'b01,
    OP_MTLO = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARM   = 2'b01,
    S_WAIT  = 2'b10,
    S_WRITE = 2'b11
  } state_t;

  localparam int ARM_CYCLES_DEFAULT = 2;

  // Two's-complement negate when neg is set; 32-bit wrap is intentional so
  // that the most negative value maps onto itself.
  function automatic logic [31:0] sign_fix(input logic [31:0] mag, input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register controller. Sequences an external divider for DIV and
// handles MTHI/MTLO directly; HI and LO only change in WRITE.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; operands latched on accept
//   S_ARM   | div_start high, div_fim ignored for ARM_CYCLES (stale fim mask)
//   S_WAIT  | div_start high, waiting for div_fim
//   S_WRITE | one cycle: update hi/lo, raise done (and div_zero_exc) next
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int ARM_CYCLES = ARM_CYCLES_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        div_start,
  output logic [31:0] div_dividendo,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_lo,
  input  logic [31:0] div_hi,
  input  logic        div_fim,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc
);

  localparam int CNT_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] ARM_LOAD = CNT_W'(ARM_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  op_t              op_q;
  logic [31:0]      rs_q;
  logic [31:0]      rt_q;
  logic [CNT_W-1:0] arm_cnt;
  logic             accept;
  logic             div_by_zero;
  logic [31:0]      lo_fixed;
  logic [31:0]      hi_fixed;

  assign accept      = (state == S_IDLE) && start;
  assign div_by_zero = (op_q == OP_DIV) && (rt_q == 32'd0);

  assign div_dividendo = rs_q;
  assign div_divisor   = rt_q;

  // Quotient sign follows the operand sign mismatch; remainder follows the dividend.
  always_comb begin
    lo_fixed = sign_fix(div_lo, rs_q[31] ^ rt_q[31]);
    hi_fixed = sign_fix(div_hi, rs_q[31]);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    div_start = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if ((op_t'(op) == OP_DIV) && (rt_val != 32'd0)) state_nx = S_ARM;
          else                                             state_nx = S_WRITE;
        end
      end
      S_ARM: begin
        div_start = 1'b1;
        if (arm_cnt == '0) state_nx = S_WAIT;
      end
      S_WAIT: begin
        div_start = 1'b1;
        if (div_fim) state_nx = S_WRITE;
      end
      S_WRITE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept; held until the next accepted request.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= OP_DIV;
      rs_q <= 32'd0;
      rt_q <= 32'd0;
    end else if (accept) begin
      op_q <= op_t'(op);
      rs_q <= rs_val;
      rt_q <= rt_val;
    end
  end

  // Arm window down-counter; terminal count at zero releases ARM.
  always_ff @(posedge clock) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (accept && (state_nx == S_ARM)) begin
      arm_cnt <= ARM_LOAD;
    end else if ((state == S_ARM) && (arm_cnt != '0)) begin
      arm_cnt <= arm_cnt - 1'b1;
    end
  end

  // Architectural HI/LO update, only in WRITE.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == S_WRITE) begin
      case (op_q)
        OP_DIV: begin
          if (!div_by_zero) begin
            lo <= lo_fixed;
            hi <= hi_fixed;
          end
        end
        OP_MTHI: hi <= rs_q;
        OP_MTLO: lo <= rs_q;
        default: ;
      endcase
    end
  end

  // Retire pulses, visible together with the updated hi/lo.
  always_ff @(posedge clock) begin
    if (reset) begin
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
    end else begin
      done         <= (state == S_WRITE);
      div_zero_exc <= (state == S_WRITE) && div_by_zero;
    end
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have parameter ARM_CYCLES, default 2: cycles div_start is held before div_fim is honoured.
REQ-002 The block SHALL have port clock, input, 1: sole clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1: one-cycle request, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2: 00 DIV, 01 MTHI, 10 MTLO, 11 reserved.
REQ-006 The block SHALL have port rs_val, input, 32: dividend, or MTHI/MTLO source.
REQ-007 The block SHALL have port rt_val, input, 32: divisor.
REQ-008 The block SHALL have port div_start, output, 1: to divider start; the divider runs only while it is high.
REQ-009 The block SHALL have ports div_dividendo and div_divisor, output, 32 each: latched operands driven to the divider.
REQ-010 The block SHALL have ports div_lo and div_hi, input, 32 each: divider magnitude quotient and remainder.
REQ-011 The block SHALL have port div_fim, input, 1: divider completion flag.
REQ-012 The block SHALL have ports hi and lo, output, 32 each: architectural HI and LO registers.
REQ-013 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1: one-cycle pulse when an operation retires.
REQ-015 The block SHALL have port div_zero_exc, output, 1: one-cycle pulse, coincident with done, on a DIV whose divisor is 0.

Function
REQ-016 The state machine SHALL have the states IDLE, ARM, WAIT and WRITE.
REQ-017 In IDLE with start=1, the block SHALL latch op, rs_val and rt_val, then transition as follows:
- DIV with rt_val!=0 goes to ARM.
- DIV with rt_val==0, MTHI, MTLO and reserved ops go to WRITE.
REQ-018 div_start SHALL equal 1 exactly in ARM and WAIT.
REQ-019 div_dividendo and div_divisor SHALL hold the latched operands from IDLE exit until WRITE exits.
REQ-020 ARM SHALL last exactly ARM_CYCLES cycles, counted by an internal counter, with div_fim ignored; this masks a stale fim left by the previous division.
REQ-021 In WAIT, div_fim=1 SHALL move the FSM to WRITE on the next edge, dropping div_start in the same cycle so the divider does not restart.
REQ-022 In WRITE for DIV (nonzero divisor), the block SHALL perform the following sign correction:
- lo <= div_lo, negated (two's complement) when rs_val[31] XOR rt_val[31].
- hi <= div_hi, negated when rs_val[31] is 1 (remainder takes the dividend's sign).
REQ-023 Sign-correction arithmetic SHALL be 32-bit and wrap: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-024 For DIV by zero, hi and lo SHALL be unchanged and div_zero_exc SHALL pulse, with no divider activity.
REQ-025 MTHI SHALL write hi<=rs_val; MTLO SHALL write lo<=rs_val; the reserved op SHALL write nothing.
REQ-026 WRITE SHALL last 1 cycle, pulse done, and return to IDLE.
REQ-027 Operation latency SHALL be as follows:
- MTHI, MTLO and reserved: done 2 cycles after start.
- DIV by zero: done 2 cycles after start.
- DIV: done at least ARM_CYCLES+2 cycles after start, set by div_fim.
REQ-028 start SHALL be ignored while busy=1, and hi and lo SHALL change only in WRITE.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL go to IDLE and clear hi, lo, done, div_zero_exc, busy, div_start, the ARM counter and the latched operands to 0.
REQ-030 Reset in ARM or WAIT SHALL abort the division, drop div_start the next cycle, and leave hi and lo at 0 with no done pulse.
REQ-031 Reset SHALL take priority over start and div_fim in the same cycle.

Structure
REQ-032 Shared package hilo_pkg SHALL hold the op encodings (OP_DIV, OP_MTHI, OP_MTLO, OP_RSVD), the state enum and the ARM_CYCLES default.
REQ-033 The block SHALL have no sub-module; sign correction SHALL be an inline combinational function.
REQ-034 The divider SHALL be a separate instance connected through the div_* ports.

Verification
REQ-035 DIV 7/2 -> lo=3, hi=1, done pulse, div_zero_exc=0.
REQ-036 DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
REQ-037 DIV 5/0 after MTHI 0xDEADBEEF -> div_zero_exc and done on the same cycle; hi=0xDEADBEEF; lo unchanged; div_start never high.
REQ-038 Back-to-back DIV 100/7 then DIV 9/3, with start re-pulsed the cycle after done -> second result lo=3, hi=0, not corrupted by stale fim.
REQ-039 reset asserted 10 cycles into WAIT -> next cycle IDLE, busy=0, hi=lo=0, no done pulse; a following DIV 8/4 -> lo=2, hi=0.
REQ-040 start pulsed while busy, with op=MTLO and value 0x1234 -> ignored; lo is unaffected by it.
